// File: rtl/rom_arbiter.sv
// Two-master round-robin ROM read arbiter: IDLE->ISSUE->WAIT->DONE, ack 3 cycles after req sampled (1 access / 4 cycles).
// Masters hold req until ack; a slow ROM is bounded by TIMEOUT wait cycles and then completes with err and zero data.
module rom_arbiter #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [11:0] m0_addr,
    input  logic [11:0] m1_addr,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] rdata,
    output logic        rom_cs,
    output logic        rom_as,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_rdy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] TMO = 4'(TIMEOUT);

    state_t     r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic [3:0] r_timer;

    logic       w_any_req;
    logic       w_grant;
    logic [3:0] w_timer_nxt;

    // Contention goes to the master that did not win last time; 1 = master 1.
    always_comb begin
        w_any_req   = m0_req | m1_req;
        w_grant     = (m0_req && m1_req) ? ~r_last_grant : m1_req;
        w_timer_nxt = r_timer + 4'd1;
    end

    // rom_addr doubles as the latched request address, so it holds outside ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_timer      <= 4'd0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_err       <= 1'b0;
            m1_err       <= 1'b0;
            rdata        <= 32'h0;
            rom_cs       <= 1'b0;
            rom_as       <= 1'b0;
            rom_addr     <= 12'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        rom_addr     <= w_grant ? m1_addr : m0_addr;
                        rom_cs       <= 1'b1;
                        rom_as       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rom_cs  <= 1'b0;
                    rom_as  <= 1'b0;
                    r_timer <= 4'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rom_rdy) begin
                        rdata   <= rom_data;
                        m0_ack  <= ~r_grant;
                        m1_ack  <= r_grant;
                        m0_err  <= 1'b0;
                        m1_err  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= w_timer_nxt;
                        if (w_timer_nxt == TMO) begin
                            rdata   <= 32'h0;
                            m0_ack  <= ~r_grant;
                            m1_ack  <= r_grant;
                            m0_err  <= ~r_grant;
                            m1_err  <= r_grant;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    m0_err  <= 1'b0;
                    m1_err  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
